// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous image ROM among NREQ sprite requesters,
// fixed 3-cycle read latency. Define SPRITE_ARB_RANGE_CHECK_EN to add an address range check.
module sprite_rom_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 15,
  parameter int DW       = 9,
  parameter int IMG_SIZE = 19200
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [AW-1:0]        rom_addr,
  input  logic [DW-1:0]        rom_data,
  output logic [NREQ-1:0]      rd_valid,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_oor
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (IMG_SIZE < 1 || IMG_SIZE > (1 << AW)) begin : g_bad_img_size
    $error("IMG_SIZE does not fit the ROM address width");
  end

  logic [IW-1:0]   last_gnt_reg;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic [AW-1:0]   win_addr;
  logic [AW-1:0]   win_rom_addr;
  logic            win_oor;

  logic [NREQ-1:0] gnt_reg;
  logic [NREQ-1:0] tag_reg;
  logic [NREQ-1:0] rd_valid_reg;
  logic            oor1_reg;
  logic            oor2_reg;
  logic            rd_oor_reg;
  logic [AW-1:0]   rom_addr_reg;
  logic [DW-1:0]   rd_data_reg;

  // Search starts one past the last winner, so a held request falls to the back of the line.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_gnt_reg) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_addr = addr[int'(win_idx)*AW +: AW];

`ifdef SPRITE_ARB_RANGE_CHECK_EN
  assign win_oor      = (int'(win_addr) >= IMG_SIZE);
  assign win_rom_addr = win_oor ? '0 : win_addr;
`else
  assign win_oor      = 1'b0;
  assign win_rom_addr = win_addr;
`endif

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      gnt_reg      <= '0;
      tag_reg      <= '0;
      rd_valid_reg <= '0;
      oor1_reg     <= 1'b0;
      oor2_reg     <= 1'b0;
      rd_oor_reg   <= 1'b0;
      rom_addr_reg <= '0;
      rd_data_reg  <= '0;
      last_gnt_reg <= IW'(NREQ - 1);
    end else begin
      gnt_reg  <= '0;
      oor1_reg <= 1'b0;
      if (win_found) begin
        gnt_reg      <= NREQ'(1) << win_idx;
        rom_addr_reg <= win_rom_addr;
        last_gnt_reg <= win_idx;
        oor1_reg     <= win_oor;
      end
      // Grantee tag follows the ROM access: stage 1 while the ROM reads, stage 2 as return strobe.
      tag_reg      <= gnt_reg;
      oor2_reg     <= oor1_reg;
      rd_valid_reg <= tag_reg;
      rd_oor_reg   <= oor2_reg & (|tag_reg);
      if (|tag_reg) begin
        rd_data_reg <= oor2_reg ? '0 : rom_data;
      end
    end
  end

  assign gnt      = gnt_reg;
  assign rom_addr = rom_addr_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign rd_oor   = rd_oor_reg;

endmodule
